// File: rtl/axi_burst_slave_mem_if.sv
// Burst bus between the INF initiator and the memory responder:
// AR/R read channel, AW/W write channel and the completion strobe.
interface axi_burst_slave_mem_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] ar_addr;
    logic              ar_valid;
    logic              ar_ready;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic              aw_valid;
    logic              aw_ready;
    logic [DATA_W-1:0] w_data;
    logic              w_valid;
    logic              w_ready;
    logic              txn_done;
    logic              txn_wr;

    modport master (
        output ar_addr, ar_valid, r_ready, aw_addr, aw_valid, w_data, w_valid,
        input  ar_ready, r_data, r_valid, aw_ready, w_ready, txn_done, txn_wr
    );

    modport slave (
        input  ar_addr, ar_valid, r_ready, aw_addr, aw_valid, w_data, w_valid,
        output ar_ready, r_data, r_valid, aw_ready, w_ready, txn_done, txn_wr
    );
endinterface

// File: rtl/axi_burst_slave_mem.sv
// Burst responder holding a 2**ADDR_W x DATA_W register-file memory; serves one
// fixed-length read or write burst at a time with programmable ready delay and read-beat gaps.
module axi_burst_slave_mem #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned READY_DLY = 1,
    parameter int unsigned R_GAP     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axi_burst_slave_mem_if.slave  bus
);
    localparam int unsigned DEPTH    = 2**ADDR_W;
    localparam int unsigned BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned CNT_MAX  = (READY_DLY > R_GAP) ? READY_DLY : R_GAP;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1) + 1;
    // The IDLE cycle that first sees valid counts as one sample, so *_WAIT
    // only runs when more than one sample is required.
    localparam int unsigned DLY_LAST = (READY_DLY > 1) ? READY_DLY - 1 : 0;
    localparam int unsigned GAP_LAST = (R_GAP > 0) ? R_GAP - 1 : 0;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_AR_WAIT = 4'd1;
    localparam logic [3:0] S_AR_ACK  = 4'd2;
    localparam logic [3:0] S_R_BEAT  = 4'd3;
    localparam logic [3:0] S_R_GAP   = 4'd4;
    localparam logic [3:0] S_AW_WAIT = 4'd5;
    localparam logic [3:0] S_AW_ACK  = 4'd6;
    localparam logic [3:0] S_W_BEAT  = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    logic [3:0]        state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [BEAT_W-1:0] beat_q,     beat_d;
    logic [ADDR_W-1:0] base_q,     base_d;
    logic              ar_ready_q, ar_ready_d;
    logic              aw_ready_q, aw_ready_d;
    logic              r_valid_q,  r_valid_d;
    logic              w_ready_q,  w_ready_d;
    logic              txn_done_q, txn_done_d;
    logic              txn_wr_q,   txn_wr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] addr;
    logic              mem_we;

    assign addr   = base_q + ADDR_W'(beat_q);
    assign mem_we = (state_q == S_W_BEAT) && w_ready_q && bus.w_valid;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        base_d     = base_q;
        ar_ready_d = 1'b0;
        aw_ready_d = 1'b0;
        r_valid_d  = 1'b0;
        w_ready_d  = 1'b0;
        txn_done_d = 1'b0;
        txn_wr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                beat_d = '0;
                if (bus.ar_valid) begin
                    if (READY_DLY > 1) begin
                        state_d = S_AR_WAIT;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d    = S_AR_ACK;
                        ar_ready_d = 1'b1;
                    end
                end else if (bus.aw_valid) begin
                    if (READY_DLY > 1) begin
                        state_d = S_AW_WAIT;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d    = S_AW_ACK;
                        aw_ready_d = 1'b1;
                    end
                end
            end
            S_AR_WAIT: begin
                if (!bus.ar_valid) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DLY_LAST)) begin
                    state_d    = S_AR_ACK;
                    ar_ready_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_AR_ACK: begin
                if (bus.ar_valid) begin
                    state_d   = S_R_BEAT;
                    base_d    = bus.ar_addr;
                    beat_d    = '0;
                    r_valid_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_R_BEAT: begin
                r_valid_d = 1'b1;
                if (bus.r_ready) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_LAST) begin
                        state_d    = S_DONE;
                        r_valid_d  = 1'b0;
                        beat_d     = '0;
                        txn_done_d = 1'b1;
                        txn_wr_d   = 1'b0;
                    end else if (R_GAP > 0) begin
                        state_d   = S_R_GAP;
                        r_valid_d = 1'b0;
                        cnt_d     = '0;
                    end
                end
            end
            S_R_GAP: begin
                if (cnt_q == CNT_W'(GAP_LAST)) begin
                    state_d   = S_R_BEAT;
                    r_valid_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_AW_WAIT: begin
                if (!bus.aw_valid) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DLY_LAST)) begin
                    state_d    = S_AW_ACK;
                    aw_ready_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_AW_ACK: begin
                if (bus.aw_valid) begin
                    state_d   = S_W_BEAT;
                    base_d    = bus.aw_addr;
                    beat_d    = '0;
                    w_ready_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_W_BEAT: begin
                w_ready_d = 1'b1;
                if (bus.w_valid) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_LAST) begin
                        state_d    = S_DONE;
                        w_ready_d  = 1'b0;
                        beat_d     = '0;
                        txn_done_d = 1'b1;
                        txn_wr_d   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            beat_q     <= '0;
            base_q     <= '0;
            ar_ready_q <= 1'b0;
            aw_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            w_ready_q  <= 1'b0;
            txn_done_q <= 1'b0;
            txn_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
            ar_ready_q <= ar_ready_d;
            aw_ready_q <= aw_ready_d;
            r_valid_q  <= r_valid_d;
            w_ready_q  <= w_ready_d;
            txn_done_q <= txn_done_d;
            txn_wr_q   <= txn_wr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[addr] <= bus.w_data;
        end
    end

    assign bus.ar_ready = ar_ready_q;
    assign bus.aw_ready = aw_ready_q;
    assign bus.r_valid  = r_valid_q;
    assign bus.w_ready  = w_ready_q;
    assign bus.txn_done = txn_done_q;
    assign bus.txn_wr   = txn_wr_q;
    assign bus.r_data   = r_valid_q ? mem_q[addr] : '0;
endmodule
